// File: rtl/atk16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atk16_pkg                                                            |
// | Shared atk16 types: memory-arbiter FSM states and requester IDs,     |
// | plus a small helper that returns the opposite requester.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package atk16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_VID = 1'b1
  } req_id_t;

  // The requester that is not 'id'; the round-robin pick on a tie.
  function automatic req_id_t other_req(input req_id_t id);
    if (id == REQ_CPU) return REQ_VID;
    return REQ_CPU;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter                                                          |
// | Two-requester (CPU read/write, video read-only) round-robin arbiter  |
// | in front of one external synchronous BRAM port. Each access takes    |
// | IDLE/ACK -> ISSUE -> RESP -> ACK; ack is a one-cycle pulse.          |
// |                                                                      |
// | Ports                                                                |
// |   clk, rst (async, active-low)                                       |
// |   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack/cpu_rdata             |
// |   vid_req/vid_addr                  -> vid_ack/vid_rdata             |
// |   mem_addr/mem_we/mem_wdata (registered BRAM drive), mem_rdata       |
// |   busy : high whenever the FSM is not in IDLE                        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_arbiter
  import atk16_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  req_id_t    r_last_grant;   // also identifies the owner of the running access
  req_id_t    w_grant_id;
  logic       w_grant;
  logic       w_other_req;
  logic       r_is_write;

  // Next state and grant decision
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_id  = REQ_CPU;
    w_other_req = (r_last_grant == REQ_CPU) ? vid_req : cpu_req;
    case (r_state)
      IDLE: begin
        if (cpu_req && vid_req) begin
          w_grant     = 1'b1;
          w_grant_id  = other_req(r_last_grant);
          w_state_nxt = ISSUE;
        end else if (cpu_req) begin
          w_grant     = 1'b1;
          w_grant_id  = REQ_CPU;
          w_state_nxt = ISSUE;
        end else if (vid_req) begin
          w_grant     = 1'b1;
          w_grant_id  = REQ_VID;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = RESP;
      RESP:  w_state_nxt = ACK;
      ACK: begin
        // The requester just served is ignored here, so a continuously
        // asserted pair alternates strictly.
        if (w_other_req) begin
          w_grant     = 1'b1;
          w_grant_id  = other_req(r_last_grant);
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; last_grant resets to VID so the CPU wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_VID;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) r_last_grant <= w_grant_id;
    end
  end

  // BRAM drive and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      r_is_write <= 1'b0;
      cpu_rdata  <= '0;
      vid_rdata  <= '0;
    end else begin
      // mem_we is raised only by a CPU-write grant, so it is high in ISSUE only
      mem_we <= 1'b0;
      if (w_grant) begin
        if (w_grant_id == REQ_CPU) begin
          mem_addr   <= cpu_addr;
          mem_wdata  <= cpu_wdata;
          mem_we     <= cpu_we;
          r_is_write <= cpu_we;
        end else begin
          mem_addr   <= vid_addr;
          r_is_write <= 1'b0;
        end
      end
      // BRAM captured the address on ISSUE->RESP; its data is valid in RESP
      if ((r_state == RESP) && !r_is_write) begin
        if (r_last_grant == REQ_CPU) cpu_rdata <= mem_rdata;
        else                         vid_rdata <= mem_rdata;
      end
    end
  end

  assign busy    = (r_state != IDLE);
  assign cpu_ack = (r_state == ACK) && (r_last_grant == REQ_CPU);
  assign vid_ack = (r_state == ACK) && (r_last_grant == REQ_VID);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter                                                       |
// | Self-checking bench for mem_arbiter with a behavioural BRAM,         |
// | a directed vector table, multi-cycle corner sequences and a          |
// | randomized two-requester run against a transaction-level model.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        vid_req, vid_ack;
  logic [15:0] vid_addr, vid_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] e_cpu;   // expected cpu_rdata
  logic [15:0] e_vid;   // expected vid_rdata

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: read-first, one-cycle read latency; unwritten words
  // hold a fixed pattern, with 0xFFFF preset to 0xBEEF.
  logic [15:0] bram [int];
  logic [15:0] bram_q;
  assign mem_rdata = bram_q;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    if (a == 16'hFFFF) return 16'hBEEF;
    return a ^ 16'hC3C3;
  endfunction

  function automatic logic [15:0] peek(input logic [15:0] a);
    if (bram.exists(int'(a))) return bram[int'(a)];
    return init_word(a);
  endfunction

  always @(posedge clk) begin
    bram_q <= peek(mem_addr);
    if (mem_we) bram[int'(mem_addr)] = mem_wdata;
  end

  // Reference memory for the randomized run
  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"},      busy,      0);
    check({tag, " cpu_ack"},   cpu_ack,   0);
    check({tag, " vid_ack"},   vid_ack,   0);
    check({tag, " mem_we"},    mem_we,    0);
    check({tag, " mem_addr"},  mem_addr,  0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
    check({tag, " cpu_rdata"}, cpu_rdata, 0);
    check({tag, " vid_rdata"}, vid_rdata, 0);
  endtask

  task automatic do_reset();
    cpu_req = 0; vid_req = 0; cpu_we = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    e_cpu = 16'h0;
    e_vid = 16'h0;
  endtask

  // One isolated access from IDLE; called and returns at a negedge.
  task automatic run_access(input string tag, input bit vid, input bit we,
                            input logic [15:0] addr, input logic [15:0] wd,
                            input logic [15:0] exp_rd);
    int lat, wcyc;
    bit got;
    if (vid) begin
      vid_req = 1; vid_addr = addr;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    lat = 0; wcyc = 0; got = 0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      if (mem_we) wcyc++;
      if (n == 1) begin
        check({tag, " mem_addr"}, mem_addr, addr);
        if (!vid && we) check({tag, " mem_wdata"}, mem_wdata, wd);
      end
      check({tag, " foreign ack"}, vid ? cpu_ack : vid_ack, 0);
      if (vid ? vid_ack : cpu_ack) begin got = 1; lat = n; end
    end
    check({tag, " ack latency"}, lat, 3);
    check({tag, " mem_we cycles"}, wcyc, (!vid && we) ? 1 : 0);
    cpu_req = 0; vid_req = 0;
    if (vid) e_vid = exp_rd;
    else if (!we) e_cpu = exp_rd;
    check({tag, " cpu_rdata"}, cpu_rdata, e_cpu);
    check({tag, " vid_rdata"}, vid_rdata, e_vid);
    @(negedge clk);
    check({tag, " idle after"}, busy, 0);
  endtask

  typedef struct {
    bit          vid;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int ca, va, acks, busy_cyc, lat;
    int cyc, c_t0, v_t0;
    bit c_p, v_p, c_w;
    logic [15:0] c_a, c_d, v_a;

    rst = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    vid_req = 0; vid_addr = 0;
    e_cpu = 0; e_vid = 0;

    // Reset state
    @(negedge clk);
    check_zero("reset");
    rst = 1;
    @(negedge clk);

    // Directed table
    tbl[0] = '{0, 1, 16'h0064, 16'h1234, 16'h0000};
    tbl[1] = '{0, 0, 16'h0064, 16'h0000, 16'h1234};
    tbl[2] = '{1, 0, 16'h0064, 16'h0000, 16'h1234};
    tbl[3] = '{1, 0, 16'hFFFF, 16'h0000, 16'hBEEF};
    tbl[4] = '{0, 1, 16'h0000, 16'hA5A5, 16'h0000};
    tbl[5] = '{0, 0, 16'h0000, 16'h0000, 16'hA5A5};
    tbl[6] = '{1, 0, 16'h0001, 16'h0000, 16'hC3C2};
    tbl[7] = '{0, 0, 16'hFFFF, 16'h0000, 16'hBEEF};
    for (int i = 0; i < 8; i++)
      run_access($sformatf("vec%0d", i), tbl[i].vid, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp);

    // Simultaneous requests straight out of reset: CPU first, video 3 later
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'h0055;
    vid_req = 1; vid_addr = 16'h0064;
    ca = 0; va = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (cpu_ack) begin if (ca == 0) ca = n; cpu_req = 0; end
      if (vid_ack) begin if (va == 0) va = n; vid_req = 0; end
      check("tie cpu_rdata hold", cpu_rdata, 16'h0000);
    end
    check("tie cpu ack edge", ca, 3);
    check("tie vid ack edge", va, 6);
    check("tie vid_rdata", vid_rdata, 16'h1234);
    check("tie idle", busy, 0);
    e_vid = 16'h1234;

    // Both requesting continuously for 12 cycles: strict alternation
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    vid_req = 1; vid_addr = 16'h0000;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check($sformatf("rr cpu_ack@%0d", n), cpu_ack, (n % 3 == 0) && ((n / 3) % 2 == 1));
      check($sformatf("rr vid_ack@%0d", n), vid_ack, (n % 3 == 0) && ((n / 3) % 2 == 0));
    end
    cpu_req = 0; vid_req = 0;
    check("rr cpu_rdata", cpu_rdata, 16'h0055);
    check("rr vid_rdata", vid_rdata, 16'hA5A5);
    e_cpu = 16'h0055; e_vid = 16'hA5A5;
    @(negedge clk);
    check("rr idle", busy, 0);

    // Video drops req in RESP: still exactly one ack with valid data
    vid_req = 1; vid_addr = 16'h0064;
    acks = 0; busy_cyc = 0; lat = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 2) vid_req = 0;
      if (busy) busy_cyc++;
      if (vid_ack) begin acks++; if (lat == 0) lat = n; end
    end
    check("drop vid ack count", acks, 1);
    check("drop vid ack edge", lat, 3);
    check("drop busy cycles", busy_cyc, 3);
    check("drop vid_rdata", vid_rdata, 16'h1234);
    e_vid = 16'h1234;

    // Reset during ISSUE of a CPU write to 0x000A: aborted, no ack
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h000A; cpu_wdata = 16'h7777;
    @(negedge clk);
    check("abort mem_we in issue", mem_we, 1);
    rst = 0;
    #1;
    check_zero("abort reset");
    cpu_req = 0; cpu_we = 0;
    repeat (2) @(negedge clk);
    check_zero("abort held");
    rst = 1;
    e_cpu = 0; e_vid = 0;
    acks = 0; busy_cyc = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
      if (busy) busy_cyc++;
    end
    check("abort no ack", acks, 0);
    check("abort stays idle", busy_cyc, 0);
    check("abort bram 0x000A", peek(16'h000A), 16'hC3C9);
    run_access("abort readback", 0, 0, 16'h000A, 16'h0000, 16'hC3C9);

    // Randomized contention against a transaction-level model
    cyc = 0; c_p = 0; v_p = 0; c_t0 = 0; v_t0 = 0;
    c_w = 0; c_a = 0; c_d = 0; v_a = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      cyc++;
      check("rand ack exclusive", cpu_ack & vid_ack, 0);
      if (cpu_ack) begin
        check("rand cpu ack pending", c_p, 1);
        if (c_p) begin
          check("rand cpu wait 3..6", (cyc - c_t0 >= 3) && (cyc - c_t0 <= 6), 1);
          if (c_w) ref_mem[int'(c_a)] = c_d;
          else     e_cpu = ref_rd(c_a);
          c_p = 0; cpu_req = 0;
        end
      end else if (c_p && (cyc - c_t0 > 6)) begin
        check("rand cpu ack timeout", cyc - c_t0, 6);
        c_p = 0; cpu_req = 0;
      end else if (!c_p && $urandom_range(0, 2) == 0) begin
        c_w = 1'($urandom_range(0, 1));
        c_a = 16'h0100 + 16'($urandom_range(0, 15));
        if (!c_w && $urandom_range(0, 7) == 0) c_a = 16'hFFFF;
        c_d = 16'($urandom);
        cpu_req = 1; cpu_we = c_w; cpu_addr = c_a; cpu_wdata = c_d;
        c_p = 1; c_t0 = cyc;
      end
      if (vid_ack) begin
        check("rand vid ack pending", v_p, 1);
        if (v_p) begin
          check("rand vid wait 3..6", (vid_ack) && (cyc - v_t0 >= 3) && (cyc - v_t0 <= 6), 1);
          e_vid = ref_rd(v_a);
          v_p = 0; vid_req = 0;
        end
      end else if (v_p && (cyc - v_t0 > 6)) begin
        check("rand vid ack timeout", cyc - v_t0, 6);
        v_p = 0; vid_req = 0;
      end else if (!v_p && $urandom_range(0, 2) == 0) begin
        v_a = 16'h0100 + 16'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) v_a = 16'hFFFF;
        vid_req = 1; vid_addr = v_a;
        v_p = 1; v_t0 = cyc;
      end
      check("rand cpu_rdata", cpu_rdata, e_cpu);
      check("rand vid_rdata", vid_rdata, e_vid);
    end
    cpu_req = 0; vid_req = 0;
    repeat (8) @(negedge clk);
    check("final idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
